// File: rtl/hc4_loader.sv
// hc4_loader: UART (8N1) program loader for the hc4 instruction ROM.
// Frame format: LEN_HI, LEN_LO, then len data bytes; the core is held in reset for the load.
module hc4_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,  // even, >= 4
    parameter int unsigned ADDR_W       = 12    // 8..16; length 0 means 2**ADDR_W bytes
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              rx,
    input  logic              load_req,
    output logic              core_nReset,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [7:0]        rom_wdata,
    output logic              busy,
    output logic              error
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam int unsigned      HI_W    = ADDR_W - 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, ERR} ctl_state_t;

    rx_state_t  r_rx_state, w_rx_nxt;
    ctl_state_t r_ctl_state, w_ctl_nxt;

    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx_byte;
    logic              r_byte_valid, r_frame_err;

    logic              r_core_nreset, r_rom_we, r_busy, r_error;
    logic [ADDR_W-1:0] r_waddr, r_addr, r_len;
    logic [7:0]        r_wdata;

    logic              w_half_done, w_full_done;
    logic              w_start, w_wr, w_hi_ok;
    logic [ADDR_W-1:0] w_last_addr;

    assign w_half_done = (r_clk_cnt == HALF_M1);
    assign w_full_done = (r_clk_cnt == FULL_M1);
    assign w_hi_ok     = ((r_rx_byte >> HI_W) == 8'd0);
    // len==0 wraps to all-ones, giving the full 2**ADDR_W byte image
    assign w_last_addr = r_len - ADDR_W'(1);

    assign core_nReset = r_core_nreset;
    assign rom_we      = r_rom_we;
    assign rom_waddr   = r_waddr;
    assign rom_wdata   = r_wdata;
    assign busy        = r_busy;
    assign error       = r_error;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_nxt = RX_START;
            RX_START: if (w_half_done) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full_done && r_bit_cnt == 3'd7) w_rx_nxt = RX_STOP;
            RX_STOP:  if (w_full_done) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                end
                RX_START: begin
                    if (w_half_done) r_clk_cnt <= '0;
                    else             r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                end
                RX_DATA: begin
                    if (w_full_done) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (w_full_done) begin
                        r_clk_cnt <= '0;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_rx_byte    <= r_shift;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: r_clk_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_ctl_state <= IDLE;
        else         r_ctl_state <= w_ctl_nxt;
    end

    always_comb begin
        w_ctl_nxt = r_ctl_state;
        w_start   = 1'b0;
        w_wr      = 1'b0;
        case (r_ctl_state)
            IDLE, ERR: begin
                if (load_req) begin
                    w_ctl_nxt = LEN_HI;
                    w_start   = 1'b1;
                end
            end
            LEN_HI: begin
                if (r_frame_err)       w_ctl_nxt = ERR;
                else if (r_byte_valid) w_ctl_nxt = w_hi_ok ? LEN_LO : ERR;
            end
            LEN_LO: begin
                if (r_frame_err)       w_ctl_nxt = ERR;
                else if (r_byte_valid) w_ctl_nxt = DATA;
            end
            DATA: begin
                // leave one cycle after the final strobe so core reset releases after it
                if (r_frame_err)                              w_ctl_nxt = ERR;
                else if (r_byte_valid)                        w_wr      = 1'b1;
                else if (r_rom_we && r_waddr == w_last_addr)  w_ctl_nxt = IDLE;
            end
            default: w_ctl_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_core_nreset <= 1'b0;
            r_rom_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= '0;
            r_addr        <= '0;
            r_len         <= '0;
        end else begin
            r_core_nreset <= (w_ctl_nxt == IDLE);
            r_busy        <= (w_ctl_nxt == LEN_HI) || (w_ctl_nxt == LEN_LO) || (w_ctl_nxt == DATA);
            r_error       <= (w_ctl_nxt == ERR);
            r_rom_we      <= w_wr;
            if (w_start) r_addr <= '0;
            if (w_wr) begin
                r_waddr <= r_addr;
                r_wdata <= r_rx_byte;
                r_addr  <= r_addr + ADDR_W'(1);
            end
            if (r_ctl_state == LEN_HI && r_byte_valid) r_len      <= ADDR_W'({r_rx_byte, 8'h00});
            if (r_ctl_state == LEN_LO && r_byte_valid) r_len[7:0] <= r_rx_byte;
        end
    end

endmodule

// File: doc/hc4_loader.md
Name: hc4_loader

Overview:
- Program loader sitting upstream of the hc4 core.
- Receives a program image over a UART serial line (8N1) and writes it byte-by-byte into the core's 4096x8 instruction ROM.
- Holds the core in reset for the whole load, then releases it so execution starts at pc 0.
- Reports busy/error status for a host or board LEDs.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit; must be an even value of at least 4.
- ADDR_W, 12, ROM address width; image length is limited to 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, all logic on posedge.
- nReset  in  1  asynchronous active-low reset.
- rx  in  1  UART serial input, idle high, LSB first, 8N1; asynchronous to clk.
- load_req  in  1  start a load; sampled each cycle; honoured only in IDLE or ERR.
- core_nReset  out  1  reset to the hc4 core, active-low, registered.
- rom_we  out  1  one-cycle ROM write strobe.
- rom_waddr  out  ADDR_W  ROM write address.
- rom_wdata  out  8  ROM write data.
- busy  out  1  high while a load is in progress (LEN_HI, LEN_LO, DATA).
- error  out  1  sticky load error.

Behaviour:
- Reset values (asynchronous, while nReset=0): core_nReset=0, rom_we=0, rom_waddr=0, rom_wdata=0, busy=0, error=0. Control FSM=IDLE, RX FSM=RX_IDLE, synchroniser flops=1.
- First posedge after nReset deasserts, in IDLE: core_nReset goes to 1.
- rx passes through a 2-flop synchroniser; all RX logic uses the synchronised value.

RX FSM:
- RX_IDLE: a falling edge on synced rx (1 to 0) -> RX_START, bit counter cleared.
- RX_START: wait CLKS_PER_BIT/2 cycles, then sample. If low -> RX_DATA. If high -> RX_IDLE as a glitch: no byte, no error.
- RX_DATA: sample every CLKS_PER_BIT cycles; 8 samples, shifted in LSB first -> RX_STOP.
- RX_STOP: after CLKS_PER_BIT cycles, sample.
  - High: one-cycle byte_valid with the byte.
  - Low: one-cycle frame_err.
  - Either way, return to RX_IDLE in the same cycle so the next start edge is accepted.

Control FSM:
- IDLE: core_nReset=1. Received bytes are discarded. load_req=1 -> LEN_HI, core_nReset=0 next cycle, error cleared, address counter=0.
- LEN_HI: on byte_valid, byte[7:4] must be 0, otherwise -> ERR. byte[3:0] becomes len[11:8] -> LEN_LO.
- LEN_LO: on byte_valid, len[7:0]=byte -> DATA. len==0 means 4096 bytes.
- DATA: on byte_valid, the next cycle has rom_we=1, rom_wdata=byte, rom_waddr=counter.
  - The counter increments after each write and wraps mod 4096.
  - After the len-th write, go to IDLE; core_nReset=1 the cycle after the last rom_we.
- ERR: error=1, busy=0, core_nReset held 0, bytes discarded. load_req -> LEN_HI, clearing error.
- frame_err in LEN_HI, LEN_LO or DATA -> ERR. Writes already issued are not undone.
- load_req while busy is ignored.
- load_req in the same cycle as byte_valid in IDLE: the byte is discarded and the load starts.
- rom_we is never high in two consecutive cycles, because byte_valid spacing is at least 10*CLKS_PER_BIT.
- rom_waddr/rom_wdata hold their last values when rom_we=0.
- nReset asserted mid-load: immediate return to the reset values above. ROM contents are left as written.

Test Plan:
- Reset: hold nReset=0 for 5 clk -> all outputs 0. Release nReset -> core_nReset=1 one posedge later; busy=0, error=0.
- Normal load: pulse load_req, send 0x00,0x03,0xA5,0x3C,0xFF -> exactly three rom_we pulses: (0x000,0xA5), (0x001,0x3C), (0x002,0xFF). core_nReset low from the cycle after load_req until the cycle after the third write; busy mirrors this window.
- Framing error: load of length 2 with the stop bit of the 0x3C data byte driven low -> one write (0x000,0xA5), then error=1, busy=0, core_nReset stays 0. A new load_req clears error and restarts at address 0.
- Bad length and IDLE traffic: send 0x55 in IDLE -> no rom_we. Then load_req followed by 0x10 -> error=1 with no writes.
- Glitch and max length: a low rx pulse of CLKS_PER_BIT/4 cycles -> no byte and no error. Length bytes 0x00,0x00 -> 4096 writes, last address 0xFFF, then core_nReset=1.
- Reset mid-load: assert nReset after 2 of 3 data bytes -> outputs return to reset values asynchronously. After release the FSM is in IDLE and a fresh load works.
